// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Purpose:
//   Round-robin arbiter that lets three requesters share one load-enabled
//   register. A request is accepted only while the FSM is idle. The winner's
//   data is registered onto reg_din and a one-cycle load strobe plus a
//   one-hot grant pulse are issued. A trailing ACK cycle gives the served
//   requester time to drop its request before the next sample.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   req[2:0]    in   load request per requester, held until its gnt bit
//   data0..2    in   write data per requester, stable while its req is high
//   reg_din     out  data bus to the shared register
//   reg_load    out  load strobe to the shared register (one cycle)
//   gnt[2:0]    out  one-hot grant pulse, coincident with reg_load
//   busy        out  high whenever the FSM is not idle
//   load_count  out  saturating count of completed loads
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] reg_din,
    output logic             reg_load,
    output logic [2:0]       gnt,
    output logic             busy,
    output logic [15:0]      load_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_last;
    logic [WIDTH-1:0] r_reg_din;
    logic             r_reg_load;
    logic [2:0]       r_gnt;
    logic             r_busy;
    logic [15:0]      r_load_count;

    // (a + b) mod 3 for a in 0..2, b in 0..3
    function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        logic [2:0] red;
        sum = {1'b0, a} + {1'b0, b};
        red = sum - 3'd3;
        if (sum >= 3'd3)
            f_mod3_add = red[1:0];
        else
            f_mod3_add = sum[1:0];
    endfunction

    // Candidate gi is the requester searched at position gi of the
    // round-robin order: last+1, last+2, last+3 (== last).
    logic [1:0] w_cand_idx [3];
    logic [2:0] w_cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            localparam logic [1:0] OFFSET = 2'(gi + 1);
            assign w_cand_idx[gi] = f_mod3_add(r_last, OFFSET);
            assign w_cand_req[gi] = (w_cand_idx[gi] == 2'd0) ? req[0] :
                                    (w_cand_idx[gi] == 2'd1) ? req[1] : req[2];
        end
    endgenerate

    logic             w_any_req;
    logic [1:0]       w_winner;
    logic [2:0]       w_win_onehot;
    logic [WIDTH-1:0] w_win_data;

    // Later assignments override earlier ones, so the earliest candidate in
    // the search order that is requesting wins. If only the previous winner
    // requests (or nobody does), the last candidate is selected; the FSM
    // ignores the result when no request is present.
    always_comb begin
        w_any_req = |req;
        w_winner  = w_cand_idx[2];
        if (w_cand_req[1])
            w_winner = w_cand_idx[1];
        if (w_cand_req[0])
            w_winner = w_cand_idx[0];
    end

    always_comb begin
        w_win_onehot = 3'b100;
        w_win_data   = data2;
        case (w_winner)
            2'd0: begin
                w_win_onehot = 3'b001;
                w_win_data   = data0;
            end
            2'd1: begin
                w_win_onehot = 3'b010;
                w_win_data   = data1;
            end
            default: begin
                w_win_onehot = 3'b100;
                w_win_data   = data2;
            end
        endcase
    end

    // Single FSM with registered outputs. Reset is asynchronous so an
    // in-flight load strobe is withdrawn immediately; because the counter
    // only advances on the LOAD->ACK edge, an interrupted load never counts.
    // last resets to 2 so requester 0 is searched first after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last       <= 2'd2;
            r_reg_din    <= '0;
            r_reg_load   <= 1'b0;
            r_gnt        <= 3'b000;
            r_busy       <= 1'b0;
            r_load_count <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ST_LOAD;
                        r_reg_din  <= w_win_data;
                        r_last     <= w_winner;
                        r_reg_load <= 1'b1;
                        r_gnt      <= w_win_onehot;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state    <= ST_ACK;
                    r_reg_load <= 1'b0;
                    r_gnt      <= 3'b000;
                    if (r_load_count != 16'hFFFF)
                        r_load_count <= r_load_count + 16'd1;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_reg_load <= 1'b0;
                    r_gnt      <= 3'b000;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign reg_din    = r_reg_din;
    assign reg_load   = r_reg_load;
    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign load_count = r_load_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req;
    logic [WIDTH-1:0] data0, data1, data2;
    logic [WIDTH-1:0] reg_din;
    logic             reg_load;
    logic [2:0]       gnt;
    logic             busy;
    logic [15:0]      load_count;

    reg_write_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .reg_din    (reg_din),
        .reg_load   (reg_load),
        .gnt        (gnt),
        .busy       (busy),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       gnt;
        logic [WIDTH-1:0] data;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] g, input logic [WIDTH-1:0] d);
        sb_item_t it;
        it.gnt  = g;
        it.data = d;
        sb_q.push_back(it);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a request pattern and drop each bit once its grant is seen.
    task automatic serve(input logic [2:0] bits, input int max_cyc);
        req = bits;
        for (int i = 0; i < max_cyc && req != 3'b000; i++) begin
            @(negedge clk);
            req = req & ~gnt;
        end
        check_val("serve_done", 64'(req), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        check_val("rst_load_count", 64'(load_count), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every load strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_load) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_load", 64'(reg_load), 64'd0);
                end else begin
                    sb_item_t e;
                    e = sb_q.pop_front();
                    $display("load: gnt=%b din=0x%0h (expected gnt=%b din=0x%0h) count=%0d",
                             gnt, reg_din, e.gnt, e.data, load_count);
                    check_val("sb_gnt", 64'(gnt), 64'(e.gnt));
                    check_val("sb_din", 64'(reg_din), 64'(e.data));
                end
            end else begin
                check_val("gnt_without_load", 64'(gnt), 64'd0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        data0 = '0;
        data1 = '0;
        data2 = '0;

        // Reset state
        wait_neg(2);
        check_val("reset_reg_din", 64'(reg_din), 64'd0);
        check_val("reset_reg_load", 64'(reg_load), 64'd0);
        check_val("reset_gnt", 64'(gnt), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_load_count", 64'(load_count), 64'd0);
        reset = 1'b0;

        // Single request
        @(negedge clk);
        data0 = 32'd12323;
        req   = 3'b001;
        push_exp(3'b001, 32'd12323);
        @(negedge clk);
        check_val("t1_load", 64'(reg_load), 64'd1);
        check_val("t1_gnt", 64'(gnt), 64'b001);
        check_val("t1_din", 64'(reg_din), 64'd12323);
        check_val("t1_busy_load", 64'(busy), 64'd1);
        req = 3'b000;
        @(negedge clk);
        check_val("t1_ack_load", 64'(reg_load), 64'd0);
        check_val("t1_ack_busy", 64'(busy), 64'd1);
        check_val("t1_count", 64'(load_count), 64'd1);
        @(negedge clk);
        check_val("t1_idle_busy", 64'(busy), 64'd0);
        check_val("t1_din_hold", 64'(reg_din), 64'd12323);

        // All requesters held, fresh priority after reset
        do_reset();
        data0 = 32'hA0A0_0001;
        data1 = 32'hB1B1_0002;
        data2 = 32'hC2C2_0003;
        req   = 3'b111;
        push_exp(3'b001, 32'hA0A0_0001);
        push_exp(3'b010, 32'hB1B1_0002);
        push_exp(3'b100, 32'hC2C2_0003);
        push_exp(3'b001, 32'hA0A0_0001);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_val("t2_load_slot", 64'(reg_load), (i % 3 == 0) ? 64'd1 : 64'd0);
        end
        req = 3'b000;
        check_val("t2_count", 64'(load_count), 64'd4);
        wait_neg(3);

        // Round-robin skip: last winner was 0, req 101 -> 2 then 0
        data0 = 32'h0000_D00D;
        data2 = 32'h0000_F00F;
        push_exp(3'b100, 32'h0000_F00F);
        push_exp(3'b001, 32'h0000_D00D);
        serve(3'b101, 20);
        wait_neg(3);
        check_val("t3_count", 64'(load_count), 64'd6);

        // Request 1 appears only during LOAD/ACK and must be ignored
        data0 = 32'h1234_5678;
        data1 = 32'hDEAD_BEEF;
        push_exp(3'b001, 32'h1234_5678);
        req = 3'b001;
        @(negedge clk);
        check_val("t4_gnt", 64'(gnt), 64'b001);
        req = 3'b010;
        @(negedge clk);
        check_val("t4_ack_busy", 64'(busy), 64'd1);
        req = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("t4_no_load", 64'(reg_load), 64'd0);
        end
        check_val("t4_count", 64'(load_count), 64'd7);
        check_val("t4_din_hold", 64'(reg_din), 64'h1234_5678);

        // Reset 3 ns into a LOAD cycle
        data0 = 32'h5555_AAAA;
        req   = 3'b001;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("t5_load_drop", 64'(reg_load), 64'd0);
        check_val("t5_gnt_drop", 64'(gnt), 64'd0);
        check_val("t5_busy_drop", 64'(busy), 64'd0);
        check_val("t5_count_clear", 64'(load_count), 64'd0);
        check_val("t5_din_clear", 64'(reg_din), 64'd0);
        @(negedge clk);
        req   = 3'b000;
        reset = 1'b0;
        @(negedge clk);
        check_val("t5_count_after", 64'(load_count), 64'd0);
        data1 = 32'h0BAD_CAFE;
        push_exp(3'b010, 32'h0BAD_CAFE);
        serve(3'b010, 10);
        wait_neg(3);
        check_val("t5_count_one", 64'(load_count), 64'd1);

        // Saturation
        force dut.r_load_count = 16'hFFFE;
        #1;
        release dut.r_load_count;
        @(negedge clk);
        check_val("t6_preset", 64'(load_count), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            data2 = 32'h7000_0000 + 32'(k);
            push_exp(3'b100, 32'h7000_0000 + 32'(k));
            serve(3'b100, 10);
            wait_neg(3);
            check_val("t6_saturate", 64'(load_count), 64'hFFFF);
        end

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the shared register.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port req, input, 3 bits: req[i] is the load request from requester i; the requester holds it high until it sees gnt[i].
REQ-005 The block SHALL have the ports data0, data1, data2, input, WIDTH bits each: the write data of each requester, held stable while its req is high.
REQ-006 The block SHALL have the port reg_din, output, WIDTH bits: the data bus to the shared register's din.
REQ-007 The block SHALL have the port reg_load, output, 1 bit: the load strobe to the shared register's load.
REQ-008 The block SHALL have the port gnt, output, 3 bits: one-hot grant pulse to the requester being served.
REQ-009 The block SHALL have the port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have the port load_count, output, 16 bits: the number of loads issued.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, LOAD and ACK, with transitions IDLE->LOAD (any req bit high at the clock edge), LOAD->ACK (unconditional) and ACK->IDLE (unconditional).
REQ-012 The block SHALL sample req only in IDLE; req changes during LOAD or ACK SHALL have no effect.
REQ-013 On the IDLE->LOAD edge, the block SHALL select the winner by round-robin: the search order is last+1, last+2, last (mod 3), where last is the previous winner.
REQ-014 On the IDLE->LOAD edge, the block SHALL register the winner's data into reg_din and store the winner index as last.
REQ-015 In LOAD, reg_load SHALL be 1 and gnt SHALL be one-hot at the winner index, for exactly one cycle.
REQ-016 In IDLE and ACK, reg_load SHALL be 0 and gnt SHALL be 3'b000.
REQ-017 reg_din SHALL hold its last value outside LOAD; it changes only on an IDLE->LOAD edge.
REQ-018 Latency SHALL be as follows: a req first seen high at edge N puts reg_load=1 during cycle N..N+1, and the shared register captures reg_din at edge N+1.
REQ-019 The block SHALL issue at most one load per 3 cycles; sustained requesters SHALL each be served once per 9 cycles when all three are requesting.
REQ-020 The ACK cycle exists so that the served requester can drop req before the next sample; a requester still high in IDLE after ACK SHALL be treated as a new request.
REQ-021 load_count SHALL increment by 1 on each LOAD->ACK edge and saturate at 16'hFFFF, with no wrap-around.
REQ-022 If req is 3'b000 in IDLE, the FSM SHALL remain in IDLE with all outputs unchanged.
REQ-023 busy SHALL be 1 in LOAD and ACK, and 0 in IDLE.

Reset
REQ-024 While reset=1, the block SHALL asynchronously force state=IDLE, reg_din=0, reg_load=0, gnt=0, busy=0, load_count=0 and last=2, so that requester 0 has first priority after reset.
REQ-025 If reset asserts during LOAD, the block SHALL drop reg_load and gnt immediately without waiting for a clock edge, and the interrupted load SHALL NOT count.
REQ-026 After reset deasserts, the first rising edge SHALL behave as an IDLE sample.

Verification
REQ-027 The bench SHALL cover single request: after reset, req=3'b001 with data0=32'd12323 -> one cycle later reg_load=1, gnt=001, reg_din=12323; then ACK; load_count=1.
REQ-028 The bench SHALL cover all requesters held: req=3'b111 held continuously -> grants in order 001, 010, 100, 001, each 3 cycles apart; load_count=4 after 12 cycles.
REQ-029 The bench SHALL cover round-robin skip: last=0, req=3'b101 -> gnt=100 first, then 001.
REQ-030 The bench SHALL cover request ignored while busy: req[1] rises during LOAD of requester 0 and falls during ACK -> no gnt to requester 1 and no extra reg_load.
REQ-031 The bench SHALL cover mid-load reset: reset pulsed 3 ns into the LOAD cycle -> reg_load=0, gnt=0 and load_count=0 at once; next req=3'b010 -> gnt=010 with data1.
REQ-032 The bench SHALL cover saturation: force load_count to 16'hFFFE, then issue 3 loads -> load_count=16'hFFFF and stays there.
